axil_onchip_mem_bridge: RTL

- AXI4-Lite slave that translates single-beat reads/writes into the chip-select/write/byteenable protocol of the 1024x32 single-port on-chip RAM.
- Sits directly upstream of the RAM and feeds its address, byteenable, chipselect, write, writedata and clken inputs.
- Consumes the RAM's readdata and returns it as AXI R beats.
- One transaction in flight at a time; read/write contention is resolved by round-robin.

---
 rtl/axil_onchip_mem_bridge_pkg.sv | 24 ++
 rtl/axil_onchip_mem_bridge_if.sv | 38 +++
 rtl/axil_onchip_mem_bridge.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/axil_onchip_mem_bridge_pkg.sv
// Shared types and constants for the AXI4-Lite to on-chip RAM bridge.
//   state_t      : bridge FSM states
//   RESP_*       : AXI response codes
//   MEM_AW_DEF   : default RAM word-address width (1024 words)
//   RD_LAT_MIN/MAX: legal range of the RAM read latency parameter
package axil_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_MEM,
    WR_RESP,
    RD_MEM,
    RD_WAIT,
    RD_RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int MEM_AW_DEF = 10;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;

endpackage

// File: rtl/axil_onchip_mem_bridge_if.sv
// AXI4-Lite single-beat bus bundle between a master and the RAM bridge.
//   slave  modport : bridge side (takes AW/W/AR/B-ready/R-ready, drives readies/responses)
//   master modport : initiator side (mirror image)
interface axil_onchip_mem_bridge_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] s_awaddr;
  logic              s_awvalid;
  logic              s_awready;
  logic [31:0]       s_wdata;
  logic [3:0]        s_wstrb;
  logic              s_wvalid;
  logic              s_wready;
  logic [1:0]        s_bresp;
  logic              s_bvalid;
  logic              s_bready;
  logic [ADDR_W-1:0] s_araddr;
  logic              s_arvalid;
  logic              s_arready;
  logic [31:0]       s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rvalid;
  logic              s_rready;

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    input  s_araddr, s_arvalid, s_rready,
    output s_awready, s_wready, s_bresp, s_bvalid,
    output s_arready, s_rdata, s_rresp, s_rvalid
  );

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    output s_araddr, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bresp, s_bvalid,
    input  s_arready, s_rdata, s_rresp, s_rvalid
  );
endinterface

// File: rtl/axil_onchip_mem_bridge.sv
// AXI4-Lite slave driving a single-port on-chip RAM (chipselect/write/
// byteenable protocol). One transaction in flight; simultaneous read and
// write requests are arbitrated round-robin.
// Ports:
//   clk, reset_n      : clock, async active-low reset
//   s (slave modport) : AXI4-Lite AW/W/B/AR/R channels
//   mem_*             : RAM address/byteenable/chipselect/write/writedata/
//                       clken outputs and readdata input
// Optional build macro AXIL_MEM_RANGE_CHECK_EN: addresses beyond the RAM
// window get SLVERR and never touch the RAM; without it they alias.
module axil_onchip_mem_bridge
  import axil_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int MEM_AW     = MEM_AW_DEF,
  parameter int RD_LATENCY = 1           // legal RD_LAT_MIN..RD_LAT_MAX
) (
  input  logic                 clk,
  input  logic                 reset_n,
  axil_onchip_mem_bridge_if.slave s,
  output logic [MEM_AW-1:0]    mem_address,
  output logic [3:0]           mem_byteenable,
  output logic                 mem_chipselect,
  output logic                 mem_write,
  output logic [31:0]          mem_writedata,
  output logic                 mem_clken,
  input  logic [31:0]          mem_readdata
);

  localparam logic [1:0] LAT = 2'(RD_LATENCY);

  state_t              state_q, state_d;
  logic                last_rd_q;   // 1: last grant was a read
  logic [MEM_AW-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [3:0]          be_q;
  logic [31:0]         rdata_q;
  logic [1:0]          resp_q;
  logic [1:0]          cnt_q;
  logic                clken_q;

  logic wr_pend, rd_pend, grant_wr, grant_rd;
  logic aw_oor, ar_oor;

  // A write needs both AW and W present; they are always taken together.
  assign wr_pend = s.s_awvalid & s.s_wvalid;
  assign rd_pend = s.s_arvalid;

`ifdef AXIL_MEM_RANGE_CHECK_EN
  assign aw_oor = |s.s_awaddr[ADDR_W-1:MEM_AW+2];
  assign ar_oor = |s.s_araddr[ADDR_W-1:MEM_AW+2];
`else
  assign aw_oor = 1'b0;
  assign ar_oor = 1'b0;
`endif

  // Byte-lane and (by default) upper address bits carry no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s.s_awaddr[1:0], s.s_araddr[1:0],
                              s.s_awaddr[ADDR_W-1:MEM_AW+2],
                              s.s_araddr[ADDR_W-1:MEM_AW+2]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    case (state_q)
      IDLE: begin
        // Under contention the type not granted last wins.
        if (wr_pend && (!rd_pend || last_rd_q)) begin
          grant_wr = 1'b1;
          state_d  = aw_oor ? WR_RESP : WR_MEM;
        end else if (rd_pend) begin
          grant_rd = 1'b1;
          state_d  = ar_oor ? RD_RESP : RD_MEM;
        end
      end
      WR_MEM:  state_d = WR_RESP;
      WR_RESP: if (s.s_bready) state_d = IDLE;
      RD_MEM:  state_d = RD_WAIT;
      RD_WAIT: if (cnt_q == LAT) state_d = RD_RESP;
      RD_RESP: if (s.s_rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_rd_q <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
      cnt_q     <= '0;
      clken_q   <= 1'b0;
    end else begin
      clken_q <= 1'b1;
      if (grant_wr) begin
        addr_q    <= s.s_awaddr[MEM_AW+1:2];
        wdata_q   <= s.s_wdata;
        be_q      <= s.s_wstrb;
        resp_q    <= aw_oor ? RESP_SLVERR : RESP_OKAY;
        last_rd_q <= 1'b0;
      end
      if (grant_rd) begin
        addr_q    <= s.s_araddr[MEM_AW+1:2];
        be_q      <= 4'hF;
        resp_q    <= ar_oor ? RESP_SLVERR : RESP_OKAY;
        last_rd_q <= 1'b1;
        if (ar_oor) rdata_q <= '0;
      end
      // cnt_q counts cycles since the RAM sampled the read address.
      if (state_q == RD_MEM) cnt_q <= 2'd1;
      if (state_q == RD_WAIT) begin
        if (cnt_q == LAT) rdata_q <= mem_readdata;
        else              cnt_q   <= cnt_q + 2'd1;
      end
    end
  end

  assign s.s_awready = grant_wr;
  assign s.s_wready  = grant_wr;
  assign s.s_arready = grant_rd;
  assign s.s_bvalid  = (state_q == WR_RESP);
  assign s.s_rvalid  = (state_q == RD_RESP);
  assign s.s_bresp   = (state_q == WR_RESP) ? resp_q : RESP_OKAY;
  assign s.s_rresp   = (state_q == RD_RESP) ? resp_q : RESP_OKAY;
  assign s.s_rdata   = rdata_q;

  assign mem_address    = addr_q;
  assign mem_byteenable = be_q;
  assign mem_writedata  = wdata_q;
  assign mem_chipselect = (state_q == WR_MEM) || (state_q == RD_MEM);
  assign mem_write      = (state_q == WR_MEM);
  assign mem_clken      = clken_q;

endmodule
